decrypt_controller: RTL and testbench
=====================================

// Module: decrypt_controller
// PURPOSE
//  Sequences one LWE decryption on the decrypt dot-product datapath. Accepts a ciphertext index, streams
//  N_ENTRIES = DIMENSION+1 secret-key / ciphertext word pairs out of two synchronous RAMs, and drives the
//  datapath row strobe. Captures the datapath result and presents it on a valid/ready output port.
//  Sits between the host command interface and the decrypt datapath plus its key/ciphertext memories.
// PARAMETERS
//  PLAINTEXT_WIDTH   6     width of the result taken from the datapath
//  CIPHERTEXT_WIDTH  10    word width of the key and ciphertext memories
//  DIMENSION         10    LWE dimension n; N_ENTRIES = DIMENSION+1 words per ciphertext
//  BIG_N             30    number of ciphertexts held in ciphertext memory
//  SK_ADDR_WIDTH     4     secret-key RAM address width; must satisfy 2**W >= N_ENTRIES
//  CT_ADDR_WIDTH     9     ciphertext RAM address width; must satisfy 2**W >= BIG_N*N_ENTRIES
//  IDX_WIDTH         5     ciphertext index width; must satisfy 2**W >= BIG_N
// PORTS
//  clk          in   1                 clock; all logic is on the rising edge
//  rst          in   1                 synchronous, active-high reset
//  start_valid  in   1                 request to decrypt ciphertext ct_index
//  start_ready  out  1                 high only in IDLE; the request is accepted when start_valid && start_ready
//  ct_index     in   IDX_WIDTH         ciphertext number, sampled on accept
//  sk_rd_en     out  1                 secret-key RAM read enable; RAM data is valid 1 cycle after the read
//  sk_addr      out  SK_ADDR_WIDTH     secret-key word index i
//  ct_rd_en     out  1                 ciphertext RAM read enable; RAM data is valid 1 cycle after the read
//  ct_addr      out  CT_ADDR_WIDTH     ct_index*N_ENTRIES + i
//  row          out  DIMENSION+1       datapath row strobe; 0 clears the accumulator, nonzero accumulates
//  dp_result    in   PLAINTEXT_WIDTH   datapath result
//  out_valid    out  1                 result available
//  out_ready    in   1                 consumer accepts the result
//  out_data     out  PLAINTEXT_WIDTH   registered result
//  out_err      out  1                 1 when ct_index >= BIG_N; out_data is then 0
//  busy         out  1                 high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE. row=0, sk_rd_en=ct_rd_en=0, addrs=0, out_valid=0, out_data=0, out_err=0, busy=0,
//   start_ready=1 from the first cycle after reset. A reset mid-operation aborts immediately: no output is produced.
//  The datapath accumulates on every edge where row!=0. row is 0 in every state except ACCUM.
//  FSM: IDLE -> CLEAR -> ACCUM -> DRAIN -> OUTPUT -> IDLE.
//   IDLE:   on accept, latch ct_index and set i=0. If ct_index>=BIG_N, set out_err=1 and out_data=0, then go
//           straight to OUTPUT with no reads issued.
//   CLEAR:  1 cycle. rd_en=1, addr for i=0, row=0.
//   ACCUM:  N_ENTRIES cycles, k=0..N_ENTRIES-1. row=k+1 (matches the data read in the previous cycle).
//           rd_en=1 with the address for k+1 while k+1<N_ENTRIES, otherwise rd_en=0.
//   DRAIN:  1 cycle. row=0. out_data<=dp_result at the end of this cycle; the accumulator clears on the same edge.
//   OUTPUT: out_valid=1. out_data and out_err are held stable until out_ready. On handshake go to IDLE;
//           out_valid drops on the next cycle.
//  Latency: accept in cycle c0 -> out_valid first high in cycle c0+N_ENTRIES+3 (c0+14 at defaults).
//   Error path: out_valid is high in cycle c0+1.
//  No overlap: start_ready=0 until the OUTPUT handshake completes. A start_valid in the same cycle as that
//   handshake is taken in the following IDLE cycle.
//  ct_addr: the base ct_index*N_ENTRIES is computed once on accept, then incremented. No multiplier in the loop.
//  Address counters never wrap: the i counter saturates at N_ENTRIES.
// STRUCTURE
//  Shared package decrypt_pkg holds the FSM state enum (IDLE, CLEAR, ACCUM, DRAIN, OUTPUT), N_ENTRIES, and the
//   address-width localparams.
//  One sub-module: decrypt_addr_gen. It holds the base latch, the i counter, and the sk/ct address registers,
//   and exposes load/step/last. The FSM stays in this file.
// TESTING
//  1. Reset then accept ct_index=0 with all-ones key, ct words=1..11:
//     out_valid at c0+14, out_data=66 mod 64=2, out_err=0.
//  2. Accept ct_index=29: ct_addr sequence is 319..329, sk_addr 0..10, row sequence 0,1..11,0.
//  3. Hold out_ready=0 for 5 cycles: out_valid and out_data stay stable, start_ready=0, row=0.
//     Release -> IDLE next cycle.
//  4. ct_index=30 (>=BIG_N): no rd_en pulses, out_valid at c0+1, out_err=1, out_data=0.
//  5. Assert rst in ACCUM at k=5: the next cycle is IDLE with all outputs at reset values.
//     A following request gives the correct result.
//  6. Back-to-back requests with start_valid held high and out_ready=1: second accept lands one cycle after the
//     first handshake. Both results are correct; the accumulator is cleared between them.

Source files
------------

// File: rtl/decrypt_pkg.sv
// rtl/decrypt_pkg.sv - shared widths, FSM states and address helper for the decrypt controller
package decrypt_pkg;
    localparam int PLAINTEXT_WIDTH  = 6;
    localparam int CIPHERTEXT_WIDTH = 10;
    localparam int DIMENSION        = 10;
    localparam int BIG_N            = 30;
    localparam int SK_ADDR_WIDTH    = 4;
    localparam int CT_ADDR_WIDTH    = 9;
    localparam int IDX_WIDTH        = 5;
    localparam int N_ENTRIES        = DIMENSION + 1;
    localparam int ROW_WIDTH        = DIMENSION + 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        OUTPUT
    } state_t;

    // First ciphertext word of a given ciphertext; only evaluated on accept.
    function automatic logic [CT_ADDR_WIDTH-1:0] ct_base(input logic [IDX_WIDTH-1:0] idx);
        return CT_ADDR_WIDTH'(idx) * CT_ADDR_WIDTH'(N_ENTRIES);
    endfunction
endpackage

// File: rtl/decrypt_if.sv
// rtl/decrypt_if.sv - host, memory and datapath signals of the decrypt controller
interface decrypt_if;
    import decrypt_pkg::*;

    logic                       start_valid;
    logic                       start_ready;
    logic [IDX_WIDTH-1:0]       ct_index;
    logic                       sk_rd_en;
    logic [SK_ADDR_WIDTH-1:0]   sk_addr;
    logic                       ct_rd_en;
    logic [CT_ADDR_WIDTH-1:0]   ct_addr;
    logic [ROW_WIDTH-1:0]       row;
    logic [PLAINTEXT_WIDTH-1:0] dp_result;
    logic                       out_valid;
    logic                       out_ready;
    logic [PLAINTEXT_WIDTH-1:0] out_data;
    logic                       out_err;
    logic                       busy;

    modport master (
        input  start_valid, ct_index, dp_result, out_ready,
        output start_ready, sk_rd_en, sk_addr, ct_rd_en, ct_addr, row,
               out_valid, out_data, out_err, busy
    );

    modport slave (
        output start_valid, ct_index, dp_result, out_ready,
        input  start_ready, sk_rd_en, sk_addr, ct_rd_en, ct_addr, row,
               out_valid, out_data, out_err, busy
    );
endinterface

// File: rtl/decrypt_addr_gen.sv
// rtl/decrypt_addr_gen.sv - word counter and key/ciphertext address registers
module decrypt_addr_gen
    import decrypt_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [IDX_WIDTH-1:0]     idx,
    input  logic                     step,
    output logic [SK_ADDR_WIDTH-1:0] sk_addr,
    output logic [CT_ADDR_WIDTH-1:0] ct_addr,
    output logic                     last
);
    localparam logic [SK_ADDR_WIDTH-1:0] I_END = SK_ADDR_WIDTH'(N_ENTRIES);

    logic [SK_ADDR_WIDTH-1:0] i_cnt;
    logic [CT_ADDR_WIDTH-1:0] ct_cnt;

    // i saturates at N_ENTRIES so a late step can never wrap into another ciphertext.
    assign last    = (i_cnt == I_END);
    assign sk_addr = i_cnt;
    assign ct_addr = ct_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            i_cnt  <= '0;
            ct_cnt <= '0;
        end else if (load) begin
            i_cnt  <= '0;
            ct_cnt <= ct_base(idx);
        end else if (step && !last) begin
            i_cnt  <= i_cnt + SK_ADDR_WIDTH'(1);
            ct_cnt <= ct_cnt + CT_ADDR_WIDTH'(1);
        end
    end
endmodule

// File: rtl/decrypt_controller.sv
// rtl/decrypt_controller.sv - sequences one LWE decryption over the dot-product datapath
module decrypt_controller
    import decrypt_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    decrypt_if.master bus
);
    state_t                     state;
    state_t                     state_nx;
    logic                       load;
    logic                       step;
    logic                       last;
    logic                       rd_en;
    logic                       accept;
    logic                       bad_index;
    logic [SK_ADDR_WIDTH-1:0]   sk_addr;
    logic [CT_ADDR_WIDTH-1:0]   ct_addr;
    logic [ROW_WIDTH-1:0]       row;
    logic [PLAINTEXT_WIDTH-1:0] out_data;
    logic                       out_err;

    assign accept    = (state == IDLE) && bus.start_valid;
    assign bad_index = (bus.ct_index >= IDX_WIDTH'(BIG_N));

    decrypt_addr_gen u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .idx     (bus.ct_index),
        .step    (step),
        .sk_addr (sk_addr),
        .ct_addr (ct_addr),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // In ACCUM the counter already points one word ahead, which is exactly the row number.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        rd_en    = 1'b0;
        row      = '0;
        unique case (state)
            IDLE: begin
                if (bus.start_valid) begin
                    if (bad_index) begin
                        state_nx = OUTPUT;
                    end else begin
                        load     = 1'b1;
                        state_nx = CLEAR;
                    end
                end
            end
            CLEAR: begin
                rd_en    = 1'b1;
                step     = 1'b1;
                state_nx = ACCUM;
            end
            ACCUM: begin
                rd_en = !last;
                row   = ROW_WIDTH'(sk_addr);
                step  = 1'b1;
                if (last) state_nx = DRAIN;
            end
            DRAIN:   state_nx = OUTPUT;
            OUTPUT:  if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_err  <= 1'b0;
        end else if (accept) begin
            out_err <= bad_index;
            if (bad_index) out_data <= '0;
        end else if (state == DRAIN) begin
            out_data <= bus.dp_result;
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.out_valid   = (state == OUTPUT);
    assign bus.sk_rd_en    = rd_en;
    assign bus.ct_rd_en    = rd_en;
    assign bus.sk_addr     = sk_addr;
    assign bus.ct_addr     = ct_addr;
    assign bus.row         = row;
    assign bus.out_data    = out_data;
    assign bus.out_err     = out_err;
endmodule

// File: tb/tb_decrypt_controller.sv
// tb/tb_decrypt_controller.sv - directed bench with memory/datapath model and cycle-level reference
module tb_decrypt_controller;
    localparam int CW = 10;
    localparam int NE = 11;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    decrypt_if bus();

    decrypt_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [CW-1:0] sk_mem [0:15];
    logic [CW-1:0] ct_mem [0:511];
    logic [CW-1:0] sk_q;
    logic [CW-1:0] ct_q;
    logic [31:0]   acc;

    always @(posedge clk) begin
        if (bus.sk_rd_en) sk_q <= sk_mem[bus.sk_addr];
        if (bus.ct_rd_en) ct_q <= ct_mem[bus.ct_addr];
        if (bus.row == '0) acc <= 32'd0;
        else               acc <= acc + 32'(sk_q) * 32'(ct_q);
    end
    assign bus.dp_result = acc[5:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_result(input int idx);
        int s;
        s = 0;
        for (int i = 0; i < NE; i++) s += int'(sk_mem[i]) * int'(ct_mem[idx * NE + i]);
        return s % 64;
    endfunction

    // Reference: time since accept drives every expected output of a valid request.
    bit m_live;
    bit m_fresh;
    int m_mode;
    int m_t;
    int m_base;
    int m_data;
    int m_err;

    initial begin
        m_live = 0;
        m_fresh = 0;
        m_mode = 0;
        m_t = 0;
        m_base = 0;
        m_data = 0;
        m_err = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_live  <= 1;
            m_mode  <= 0;
            m_t     <= 0;
            m_fresh <= 1;
        end else if (m_live) begin
            case (m_mode)
                0: if (bus.start_valid) begin
                    m_fresh <= 0;
                    if (int'(bus.ct_index) >= 30) begin
                        m_err  <= 1;
                        m_data <= 0;
                        m_mode <= 2;
                    end else begin
                        m_err  <= 0;
                        m_data <= ref_result(int'(bus.ct_index));
                        m_base <= int'(bus.ct_index) * NE;
                        m_t    <= 1;
                        m_mode <= 1;
                    end
                end
                1: begin
                    m_t <= m_t + 1;
                    if (m_t == 13) m_mode <= 2;
                end
                default: if (bus.out_ready) m_mode <= 0;
            endcase
        end
    end

    bit e_rd;
    int e_row;

    always @(negedge clk) begin
        if (m_live) begin
            e_rd  = (m_mode == 1) && (m_t <= 11);
            e_row = (m_mode == 1 && m_t >= 2 && m_t <= 12) ? m_t - 1 : 0;
            check("start_ready", 32'(bus.start_ready), 32'(m_mode == 0));
            check("busy",        32'(bus.busy),        32'(m_mode != 0));
            check("out_valid",   32'(bus.out_valid),   32'(m_mode == 2));
            check("sk_rd_en",    32'(bus.sk_rd_en),    32'(e_rd));
            check("ct_rd_en",    32'(bus.ct_rd_en),    32'(e_rd));
            check("row",         32'(bus.row),         32'(e_row));
            if (e_rd) begin
                check("sk_addr", 32'(bus.sk_addr), 32'(m_t - 1));
                check("ct_addr", 32'(bus.ct_addr), 32'(m_base + m_t - 1));
            end
            if (m_mode == 2) begin
                check("out_data", 32'(bus.out_data), 32'(m_data));
                check("out_err",  32'(bus.out_err),  32'(m_err));
            end
            if (m_mode == 0 && m_fresh) begin
                check("reset_out_data", 32'(bus.out_data), 32'd0);
                check("reset_out_err",  32'(bus.out_err),  32'd0);
                check("reset_ct_addr",  32'(bus.ct_addr),  32'd0);
            end
        end
    end

    task automatic run_one(input int idx, input int hold, input int exp_data, input int exp_err,
                           input int exp_lat);
        int n;
        bit seen;
        bus.ct_index    = 5'(idx);
        bus.start_valid = 1'b1;
        bus.out_ready   = (hold == 0);
        n = 0;
        seen = 0;
        while (!seen && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) bus.start_valid = 1'b0;
            if (bus.out_valid) seen = 1;
        end
        check("latency", seen ? n : -1, exp_lat);
        check("lit_out_data", 32'(bus.out_data), 32'(exp_data));
        check("lit_out_err",  32'(bus.out_err),  32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid",       32'(bus.out_valid),   32'd1);
            check("hold_data",        32'(bus.out_data),    32'(exp_data));
            check("hold_start_ready", 32'(bus.start_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_after_handshake", 32'(bus.start_ready), 32'd1);
        check("valid_dropped",        32'(bus.out_valid),   32'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.start_valid = 1'b0;
        bus.out_ready   = 1'b0;
        bus.ct_index    = '0;
        sk_q = '0;
        ct_q = '0;
        acc = 32'd0;
        for (int a = 0; a < 16; a++) sk_mem[a] = 10'd1;
        for (int a = 0; a < 512; a++) ct_mem[a] = 10'((a * 7) % 1024);
        for (int i = 0; i < NE; i++) ct_mem[i] = 10'(i + 1);
        for (int i = 0; i < NE; i++) ct_mem[319 + i] = 10'(3 * i + 2);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",        32'(bus.busy),        32'd0);
        check("rst_start_ready", 32'(bus.start_ready), 32'd1);
        check("rst_row",         32'(bus.row),         32'd0);
        check("rst_sk_rd_en",    32'(bus.sk_rd_en),    32'd0);
        check("rst_out_valid",   32'(bus.out_valid),   32'd0);
        check("rst_out_data",    32'(bus.out_data),    32'd0);
        rst = 1'b0;

        check("model_idx0",  ref_result(0),  2);
        check("model_idx29", ref_result(29), 59);

        run_one(0, 0, 2, 0, 14);
        run_one(29, 0, 59, 0, 14);
        run_one(29, 5, 59, 0, 14);
        run_one(30, 0, 0, 1, 1);

        for (int i = 0; i < NE; i++) sk_mem[i] = 10'(i + 1);
        check("model_sq_idx0",  ref_result(0),  58);
        check("model_sq_idx29", ref_result(29), 44);

        // Reset while accumulating at k=5, then a clean request.
        bus.ct_index = 5'd29;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_accum_row", 32'(bus.row), 32'd6);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy",      32'(bus.busy),      32'd0);
        check("abort_row",       32'(bus.row),       32'd0);
        check("abort_rd_en",     32'(bus.ct_rd_en),  32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_sk_addr",   32'(bus.sk_addr),   32'd0);
        rst = 1'b0;
        run_one(0, 0, 58, 0, 14);

        // Back-to-back with start_valid held high.
        bus.ct_index = 5'd0;
        bus.start_valid = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (bus.out_valid) seen = 1;
        end
        check("b2b_first_latency", seen ? n : -1, 14);
        check("b2b_first_data", 32'(bus.out_data), 32'd58);
        bus.ct_index = 5'd29;
        @(posedge clk); #1;
        check("b2b_gap_ready", 32'(bus.start_ready), 32'd1);
        n = 0;
        seen = 0;
        while (!seen && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) bus.start_valid = 1'b0;
            if (bus.out_valid) seen = 1;
        end
        check("b2b_second_latency", seen ? n : -1, 14);
        check("b2b_second_data", 32'(bus.out_data), 32'd44);
        @(posedge clk); #1;
        check("b2b_idle", 32'(bus.start_ready), 32'd1);
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
